// File: rtl/instr_fetch.sv
// instr_fetch: PC / instruction-fetch stage of the 9-bit basic processor.
// Holds the PC, drives the ROM address, forwards the fetched word to the
// decoder, and runs an IDLE/RUN/HALT machine with a Start/Done handshake.
// Optional feature macro: FETCH_REL_JUMP_EN. When it is defined, jump-LUT
// entries are signed PC-relative offsets. When it is undefined, they are
// absolute target addresses.
module instr_fetch #(
  parameter int PC_W       = 10,
  parameter int INSTR_W    = 9,
  parameter int LUT_IDX_W  = 5,
  parameter int START_ADDR = 0
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic                 jump_en,
  input  logic [LUT_IDX_W-1:0] jump_idx,
  input  logic                 halt_req,
  input  logic                 lut_we,
  input  logic [LUT_IDX_W-1:0] lut_waddr,
  input  logic [PC_W-1:0]      lut_wdata,
  output logic [PC_W-1:0]      imem_addr,
  input  logic [INSTR_W-1:0]   imem_rdata,
  output logic [INSTR_W-1:0]   instr_out,
  output logic                 instr_valid,
  output logic                 Done,
  output logic [15:0]          instr_count
);

  localparam int              LUT_N    = 2 ** LUT_IDX_W;
  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

  state_t          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [15:0]     cnt, cnt_nxt;
  logic [PC_W-1:0] lut [LUT_N];
  logic [PC_W-1:0] jump_tgt;

  // The LUT read sees register contents, so a same-cycle write is not visible
  // until the next cycle.
`ifdef FETCH_REL_JUMP_EN
  assign jump_tgt = pc + lut[jump_idx];
`else
  assign jump_tgt = lut[jump_idx];
`endif

  // State, PC and instruction-count registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Jump LUT. It is writable in every state and is cleared by reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < LUT_N; i++) lut[i] <= '0;
    end else if (lut_we) begin
      lut[lut_waddr] <= lut_wdata;
    end
  end

  // Next state, next PC and count. In RUN the order of priority is halt, then jump, then increment.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    cnt_nxt   = cnt;
    case (state)
      IDLE, HALT: begin
        if (Start) begin
          state_nxt = RUN;
          pc_nxt    = START_PC;
          cnt_nxt   = '0;
        end
      end
      RUN: begin
        cnt_nxt = (&cnt) ? cnt : cnt + 16'd1;
        if (halt_req)     state_nxt = HALT;
        else if (jump_en) pc_nxt    = jump_tgt;
        else              pc_nxt    = pc + 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from state, so a reset clears them without delay.
  always_comb begin
    imem_addr   = pc;
    instr_valid = (state == RUN);
    Done        = (state == HALT);
    instr_out   = instr_valid ? imem_rdata : '0;
    instr_count = cnt;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Program-counter and instruction-fetch stage of the 9-bit basic processor, directly upstream of the combinational control decoder. Holds the PC, presents the instruction-ROM address, and forwards the fetched 9-bit word to the decoder. It advances sequentially or jumps through a loadable jump-target lookup table when the decoder raises `jump_en`. A small run/halt state machine with a start/done handshake controls execution, and a saturating counter reports executed instructions.

## Interface
- `PC_W`, 10, PC and instruction-ROM address width (1024 words)
- `INSTR_W`, 9, instruction width
- `LUT_IDX_W`, 5, jump-LUT index width (32 entries)
- `START_ADDR`, 0, PC value loaded when a program starts
- `Clk` in 1: single clock; all state updates on rising edge
- `Reset` in 1: asynchronous, active-high reset
- `Start` in 1: level-sampled request to begin or restart a program
- `jump_en` in 1: from decoder; take the jump this cycle
- `jump_idx` in LUT_IDX_W: LUT index (decoder passes instruction[4:0])
- `halt_req` in 1: from decoder; current instruction is halt
- `lut_we` in 1: jump-LUT write enable
- `lut_waddr` in LUT_IDX_W: LUT write index
- `lut_wdata` in PC_W: LUT write data
- `imem_addr` out PC_W: instruction-ROM address, equal to PC
- `imem_rdata` in INSTR_W: combinational ROM read data for `imem_addr`
- `instr_out` out INSTR_W: instruction to decoder
- `instr_valid` out 1: `instr_out` is executing this cycle
- `Done` out 1: program halted
- `instr_count` out 16: instructions executed since last start

## Operation
- States: IDLE, RUN, HALT.
- IDLE: PC holds; `instr_valid`=0; `Done`=0. When `Start`=1, go to RUN. PC <= START_ADDR and `instr_count` <= 0.
- RUN: `instr_valid`=1; `instr_out` = `imem_rdata`, combinational pass-through.
  - If `halt_req`=1: go to HALT, PC holds, and `instr_count` increments. The halt instruction counts.
  - Else if `jump_en`=1: PC <= jump target.
  - Else: PC <= PC+1, wrapping modulo 2^PC_W. Address 1023 is followed by 0.
  - `instr_count` increments once per RUN cycle and saturates at 16'hFFFF.
  - `Start` is ignored while in RUN.
- HALT: `Done`=1; `instr_valid`=0; PC and `instr_count` hold.
  - `Start`=1 returns to RUN, with PC <= START_ADDR, `instr_count` <= 0, and `Done` deasserted on the next cycle.
- Priority when signals coincide: `halt_req` > `jump_en` > increment.
- Outside RUN, `instr_out` = 0 and `jump_en`/`halt_req` are ignored.
- Jump LUT: 2^LUT_IDX_W registers of PC_W bits.
  - Written when `lut_we`=1, in any state.
  - A read of an index written in the same cycle returns the old value.
  - Jump target = LUT[`jump_idx`], interpreted as described under Configuration.

## Timing
- Reset asserted: state=IDLE, PC=0, all LUT entries=0, `instr_count`=0. Outputs: `instr_valid`=0, `Done`=0, `instr_out`=0, `imem_addr`=0.
- Reset mid-RUN: the block enters IDLE immediately; an in-flight jump is discarded.
- Fetch latency: 0 cycles from `imem_addr` to `instr_out`. Next-PC takes effect at the next rising edge, so one instruction executes per cycle.
- `Start` to first valid instruction: 1 cycle. The cycle after `Start` is sampled shows `imem_addr`=START_ADDR with `instr_valid`=1.
- `halt_req` to `Done`: 1 cycle.

## Configuration
- `FETCH_REL_JUMP_EN`:
  - Defined: the LUT entry is a signed PC_W-bit offset. Target = (PC + LUT[`jump_idx`]) mod 2^PC_W, where PC is the address of the jumping instruction.
  - Undefined: the LUT entry is an absolute target address.

## Test plan
- Reset, write LUT[3]=100, pulse `Start` -> `imem_addr` sequence 0,1,2,… with `instr_valid`=1; `instr_count` equals the number of RUN cycles.
- Absolute mode: at PC=5 assert `jump_en` with `jump_idx`=3 -> next `imem_addr`=100, then 101.
- `FETCH_REL_JUMP_EN` defined, LUT[2]=10'h3FE (-2): jump at PC=7 -> next PC=5. Jump at PC=1 with LUT[4]=10'h3FC (-4) -> next PC=1021 (wrap).
- At PC=1023 with no jump -> next PC=0. At PC=20, assert `halt_req` and `jump_en` together -> `Done`=1 next cycle, PC stays 20, LUT target is not taken.
- In HALT, pulse `Start` -> PC=0, `instr_count`=0, `Done`=0 on the following cycle. Assert `Reset` mid-RUN at PC=40 -> PC=0, state IDLE, all outputs at reset values immediately.
- Write LUT[7]=50 in the same cycle as a jump via index 7 (old value 0) -> target 0. A later jump via index 7 -> target 50.
